// File: rtl/cholesky_pkg.sv
// rtl/cholesky_pkg.sv - shared types and constants for the Cholesky sequencer slice
package cholesky_pkg;

    localparam int STEP_W     = 5;
    localparam int WORD_W     = 27;
    localparam int N          = 6;
    localparam int MULT_LANES = 15;
    localparam int DIV_LANES  = 5;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        COMMIT,
        DONE
    } cholesky_seq_state_t;

    // Phase timer width: enough bits for max(a,b)-1, never narrower than 1 bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cholesky_phase_timer.sv
// rtl/cholesky_phase_timer.sv - loadable down-counter with zero flag for phase latencies
module cholesky_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cholesky_sequencer.sv
// rtl/cholesky_sequencer.sv - step/phase controller for the 6x6 Cholesky datapath (optional CHOLESKY_SEQ_PERF_EN)
module cholesky_sequencer
    import cholesky_pkg::*;
#(
    parameter int NUM_STEPS = 18,
    parameter int MULT_LAT  = 5,
    parameter int DIV_LAT   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step,
    output logic              en,
    output logic              mult_start,
`ifdef CHOLESKY_SEQ_PERF_EN
    output logic [15:0]       cycle_count,
`endif
    output logic              div_start
);

    localparam int TW = timer_width(MULT_LAT, DIV_LAT);
    localparam logic [TW-1:0]     MULT_LOAD = TW'(MULT_LAT - 1);
    localparam logic [TW-1:0]     DIV_LOAD  = TW'(DIV_LAT - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    cholesky_seq_state_t state;
    cholesky_seq_state_t state_next;
    logic [STEP_W-1:0]   step_next;
    logic                timer_load;
    logic [TW-1:0]       timer_value;
    logic [TW-1:0]       timer_count;
    logic                timer_zero;

    cholesky_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    // State and step registers; step only moves when leaving COMMIT or returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_next;
            step  <= step_next;
        end
    end

    // Next-state logic; the phase timer is reloaded on every MULT/DIV entry.
    always_comb begin
        state_next  = state;
        step_next   = step;
        timer_load  = 1'b0;
        timer_value = MULT_LOAD;
        if (state != IDLE && abort) begin
            state_next = IDLE;
            step_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    step_next = '0;
                    if (start) begin
                        state_next  = MULT;
                        timer_load  = 1'b1;
                        timer_value = MULT_LOAD;
                    end
                end
                MULT: begin
                    if (timer_zero) begin
                        state_next  = DIV;
                        timer_load  = 1'b1;
                        timer_value = DIV_LOAD;
                    end
                end
                DIV: begin
                    if (timer_zero) begin
                        state_next = COMMIT;
                    end
                end
                COMMIT: begin
                    if (step == LAST_STEP) begin
                        state_next = DONE;
                    end else begin
                        state_next  = MULT;
                        step_next   = step + STEP_W'(1);
                        timer_load  = 1'b1;
                        timer_value = MULT_LOAD;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    step_next  = '0;
                end
                default: begin
                    state_next = IDLE;
                    step_next  = '0;
                end
            endcase
        end
    end

    // Moore decode: launch pulses fire while the timer still holds its freshly loaded value.
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign en         = (state == COMMIT);
    assign mult_start = (state == MULT) && (timer_count == MULT_LOAD);
    assign div_start  = (state == DIV)  && (timer_count == DIV_LOAD);

`ifdef CHOLESKY_SEQ_PERF_EN
    // Run-length counter: cleared on accepted start, saturating count of busy cycles, held in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (state == IDLE && start) begin
            cycle_count <= '0;
        end else if (busy && cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cholesky_sequencer.sv
// tb/tb_cholesky_sequencer.sv - self-checking bench for cholesky_sequencer (default and 1/1/1 configs)
module tb_cholesky_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic abort = 1'b0;

    logic       a_busy, a_done, a_en, a_ms, a_ds;
    logic [4:0] a_step;
    logic       b_busy, b_done, b_en, b_ms, b_ds;
    logic [4:0] b_step;
`ifdef CHOLESKY_SEQ_PERF_EN
    logic [15:0] a_cc, b_cc;
    int          m_cc_a, m_cc_b;
`endif

    int n_checks = 0;
    int n_pass = 0;
    int n_prints = 0;
    int ta = 0;
    int tb_t = 0;
    bit chk_en = 1'b0;

    int first_ms, last_ms, n_ms, first_ds, first_en, last_en, first_done, n_done, max_step;
    int busy_at, step_at;

    cholesky_sequencer dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .abort      (abort),
        .busy       (a_busy),
        .done       (a_done),
        .step       (a_step),
        .en         (a_en),
        .mult_start (a_ms),
`ifdef CHOLESKY_SEQ_PERF_EN
        .cycle_count(a_cc),
`endif
        .div_start  (a_ds)
    );

    cholesky_sequencer #(
        .NUM_STEPS(1),
        .MULT_LAT (1),
        .DIV_LAT  (1)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .abort      (abort),
        .busy       (b_busy),
        .done       (b_done),
        .step       (b_step),
        .en         (b_en),
        .mult_start (b_ms),
`ifdef CHOLESKY_SEQ_PERF_EN
        .cycle_count(b_cc),
`endif
        .div_start  (b_ds)
    );

    always #5 clk = ~clk;

    // Expected outputs from run position t (0 = idle, 1 = first cycle after start accepted).
    // Packing: {busy, done, en, mult_start, div_start, step[4:0]}
    function automatic logic [9:0] expect_out(input int t, input int ns, input int ml, input int dl);
        int p, k, r;
        logic [9:0] v;
        p = ml + dl + 1;
        v = '0;
        if (t >= 1 && t <= ns * p) begin
            k = (t - 1) / p;
            r = (t - 1) % p;
            v[9] = 1'b1;
            v[7] = (r == p - 1);
            v[6] = (r == 0);
            v[5] = (r == ml);
            v[4:0] = 5'(k);
        end else if (t == ns * p + 1) begin
            v[9] = 1'b1;
            v[8] = 1'b1;
            v[4:0] = 5'(ns - 1);
        end
        return v;
    endfunction

    function automatic int advance(input int t, input logic st, input logic ab,
                                   input int ns, input int ml, input int dl);
        int p;
        p = ml + dl + 1;
        if (t == 0) return st ? 1 : 0;
        if (ab) return 0;
        if (t == ns * p + 1) return 0;
        return t + 1;
    endfunction

    task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else if (n_prints < 40) begin
            n_prints++;
            $display("FAIL %s at %0t: got {busy,done,en,ms,ds,step}=%b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model advance.
    always @(posedge clk) begin
        if (rst) begin
            ta   <= 0;
            tb_t <= 0;
        end else begin
            ta   <= advance(ta, start_a, abort, 18, 5, 6);
            tb_t <= advance(tb_t, start_b, abort, 1, 1, 1);
        end
`ifdef CHOLESKY_SEQ_PERF_EN
        if (rst) begin
            m_cc_a <= 0;
            m_cc_b <= 0;
        end else begin
            if (ta == 0) begin
                if (start_a) m_cc_a <= 0;
            end else if (m_cc_a < 65535) begin
                m_cc_a <= m_cc_a + 1;
            end
            if (tb_t == 0) begin
                if (start_b) m_cc_b <= 0;
            end else if (m_cc_b < 65535) begin
                m_cc_b <= m_cc_b + 1;
            end
        end
`endif
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check_vec("dut_a", {a_busy, a_done, a_en, a_ms, a_ds, a_step}, expect_out(ta, 18, 5, 6));
            check_vec("dut_b", {b_busy, b_done, b_en, b_ms, b_ds, b_step}, expect_out(tb_t, 1, 1, 1));
`ifdef CHOLESKY_SEQ_PERF_EN
            check_int("cycle_count_a", int'(a_cc), m_cc_a);
            check_int("cycle_count_b", int'(b_cc), m_cc_b);
`endif
        end
    end

    // Watch dut_a for ncyc cycles after a start edge, optionally pulsing abort or rst.
    task automatic observe_a(input int ncyc, input bit hold, input int abort_at, input int rst_at);
        first_ms = -1; last_ms = -1; n_ms = 0; first_ds = -1; first_en = -1; last_en = -1;
        first_done = -1; n_done = 0; max_step = 0; busy_at = -1; step_at = -1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (i == 1 && !hold) start_a = 1'b0;
            if (a_ms) begin
                n_ms++;
                if (first_ms < 0) first_ms = i;
                last_ms = i;
            end
            if (a_ds && first_ds < 0) first_ds = i;
            if (a_en) begin
                if (first_en < 0) first_en = i;
                last_en = i;
            end
            if (a_done) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
            if (int'(a_step) > max_step) max_step = int'(a_step);
            if (i == abort_at + 1 || i == rst_at + 1) begin
                busy_at = int'(a_busy);
                step_at = int'(a_step);
            end
            if (i == abort_at) abort = 1'b1;
            if (i == abort_at + 1) abort = 1'b0;
            if (i == rst_at) rst = 1'b1;
            if (i == rst_at + 1) rst = 1'b0;
        end
        start_a = 1'b0;
    endtask

    initial begin
        int ms_c, ds_c, en_c, dn_c;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;

        // Idle after reset.
        repeat (10) @(negedge clk);
        check_int("idle_busy", int'(a_busy), 0);
        check_int("idle_step", int'(a_step), 0);

        // Minimal configuration run.
        start_b = 1'b1;
        ms_c = -1; ds_c = -1; en_c = -1; dn_c = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start_b = 1'b0;
            if (b_ms && ms_c < 0) ms_c = i;
            if (b_ds && ds_c < 0) ds_c = i;
            if (b_en && en_c < 0) en_c = i;
            if (b_done && dn_c < 0) dn_c = i;
        end
        check_int("small_mult_cycle", ms_c, 1);
        check_int("small_div_cycle", ds_c, 2);
        check_int("small_en_cycle", en_c, 3);
        check_int("small_done_cycle", dn_c, 4);
`ifdef CHOLESKY_SEQ_PERF_EN
        check_int("small_cycle_count", int'(b_cc), 4);
`endif

        // Full default run with a start pulse.
        start_a = 1'b1;
        observe_a(225, 1'b0, -5, -5);
        check_int("run_first_mult", first_ms, 1);
        check_int("run_last_mult", last_ms, 205);
        check_int("run_n_mult", n_ms, 18);
        check_int("run_first_div", first_ds, 6);
        check_int("run_first_en", first_en, 12);
        check_int("run_last_en", last_en, 216);
        check_int("run_done_cycle", first_done, 217);
        check_int("run_n_done", n_done, 1);
        check_int("run_max_step", max_step, 17);
        check_int("run_busy_after", int'(a_busy), 0);
`ifdef CHOLESKY_SEQ_PERF_EN
        check_int("run_cycle_count", int'(a_cc), 217);
`endif

        // Start held high: one run, next run begins right after the IDLE return.
        start_a = 1'b1;
        observe_a(230, 1'b1, -5, -5);
        check_int("hold_n_done", n_done, 1);
        check_int("hold_done_cycle", first_done, 217);
        check_int("hold_restart_mult", last_ms, 219);
        check_int("hold_n_mult", n_ms, 19);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);

        // Abort at cycle 30.
        start_a = 1'b1;
        observe_a(60, 1'b0, 30, -5);
        check_int("abort_busy", busy_at, 0);
        check_int("abort_step", step_at, 0);
        check_int("abort_n_done", n_done, 0);
        check_int("abort_last_mult", last_ms, 25);

        // Abort during COMMIT: en still seen that cycle.
        start_a = 1'b1;
        observe_a(20, 1'b0, 12, -5);
        check_int("abort_commit_en", last_en, 12);
        check_int("abort_commit_busy", busy_at, 0);
        check_int("abort_commit_n_mult", n_ms, 1);

        // Reset in step 5 DIV.
        start_a = 1'b1;
        observe_a(80, 1'b0, -5, 67);
        check_int("rst_busy", busy_at, 0);
        check_int("rst_step", step_at, 0);
        check_int("rst_n_done", n_done, 0);

        // Fresh start together with abort in IDLE: start wins.
        start_a = 1'b1;
        abort = 1'b1;
        observe_a(220, 1'b0, 0, -5);
        check_int("fresh_done_cycle", first_done, 217);
        check_int("fresh_n_done", n_done, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
